corner_tracker: RTL and testbench
=================================

// Module: corner_tracker
// PURPOSE
//  Parametrised successor of the per-frame extreme-point corner finder on the camera/VGA path.
//  - Consumes a raster-ordered binary mask stream and reports four extreme points per frame.
//  - Applies a pixel-count success threshold and holds the last good corners through brief dropouts.
//  - Sits between the colour-threshold stage and the perspective/overlay logic.
// PARAMETERS
//  FRAME_W    800  pixels per line (2..2**COORD_W)
//  FRAME_H    600  lines per frame (2..2**COORD_W)
//  COORD_W    10   bits per row/col coordinate; address = {row,col}, 2*COORD_W bits
//  CNT_W      8    width of the saturating mask-pixel counter
//  MIN_PIX    255  success threshold: frame succeeds when count >= MIN_PIX (MIN_PIX <= 2**CNT_W-1)
//  MISS_HOLD  2    consecutive failed frames that keep the last good corners (0 = revert immediately)
// PORTS
//  i_clk      in   1          pixel clock
//  i_rst      in   1          synchronous reset, active-high
//  i_valid    in   1          one mask pixel presented this cycle
//  i_data     in   1          mask value of the pixel (1 = object)
//  i_sof      in   1          qualified by i_valid: this pixel is row 0, col 0 (counter resync)
//  o_valid    out  1          1-cycle pulse: corner outputs updated for the frame just ended
//  o_success  out  1          last completed frame met MIN_PIX
//  o_held     out  1          outputs hold the previous good corners (current frame failed)
//  o_ul_addr  out  2*COORD_W  topmost point   {row,col}
//  o_ur_addr  out  2*COORD_W  rightmost point
//  o_dl_addr  out  2*COORD_W  leftmost point
//  o_dr_addr  out  2*COORD_W  bottommost point
// BEHAVIOUR
//  - Clock is i_clk; reset is i_rst, synchronous and active-high. Everything advances only on i_valid beats.
//  - Reset: counters 0, o_valid=0, o_success=0, o_held=0, miss count 0,
//    ul={0,0}, ur={0,FRAME_W-1}, dl={FRAME_H-1,0}, dr={FRAME_H-1,FRAME_W-1}; these are the "defaults".
//  - Raster: col increments to FRAME_W-1 then wraps to 0 with row+1; row wraps at FRAME_H-1.
//    i_sof&i_valid forces that beat to (0,0), regardless of counter state. A mid-frame resync discards partial trackers.
//  - Trackers: the first beat of a frame (position (0,0)) compares against sentinels, not against registers:
//    top=row max, bottom=row 0, left=col max, right=col 0; count seeds to 0.
//  - Per i_data=1 beat (strict vs non-strict comparisons define tie-breaks):
//    top: row < top.row (first hit wins); bottom: row >= bottom.row (last hit);
//    left: col <= left.col (last hit); right: col > right.col (first hit); count +1, saturating at 2**CNT_W-1.
//  - Frame end = beat at (FRAME_H-1,FRAME_W-1), its data included. o_valid=1 on the next cycle, for 1 cycle.
//    Pass (count>=MIN_PIX): outputs <= trackers, o_success=1, o_held=0, miss=0.
//    Fail with miss<MISS_HOLD: outputs unchanged, o_success=0, o_held=1, miss+1.
//    Fail with miss>=MISS_HOLD: outputs <= defaults, o_success=0, o_held=0, miss saturates.
//  - Outputs and flags are stable between o_valid pulses. A stall (i_valid=0) freezes all state.
//  - Reset mid-frame: all state returns to reset values; the next beat counts as (0,0).
//  - Coordinate arithmetic is unsigned COORD_W. No underflow is possible.
// CONFIGURATION
//  CORNER_SMOOTH_EN defined: on a pass whose previous frame also passed, each coordinate output is
//    (old + new + 1) >> 1 (COORD_W+1-bit sum, rounded half-up). A first pass after a fail or after reset loads raw trackers.
//  CORNER_SMOOTH_EN undefined: outputs load raw trackers on every pass, as above. No smoothing registers.
// TESTING (FRAME_W=16, FRAME_H=8, MIN_PIX=4, MISS_HOLD=1 unless noted)
//  - Square mask rows 2..5, cols 3..9 -> o_valid 1 cycle after (7,15); ul={2,3} ur={2,9} dl={5,3} dr={5,9}, success=1.
//  - 3 mask pixels only -> success=0, held=1, corners unchanged. Next empty frame -> defaults {0,0},{0,15},{7,0},{7,15}, held=0.
//  - Saturation: all-ones frame with CNT_W=4 -> count stops at 15, success=1; dr={7,15} and ul={0,0}.
//  - i_sof asserted at counter (3,5) -> that beat is (0,0); o_valid occurs exactly FRAME_W*FRAME_H beats later, partial data discarded.
//  - i_valid toggled 50% random while mask is identical to test 1 -> identical results; i_rst pulse mid-frame -> all outputs at reset values.
//  - CORNER_SMOOTH_EN: pass with ul={2,3} then pass with ul={5,8} -> ul={4,6}. Without the macro -> ul={5,8}.

Source files
------------

// File: rtl/corner_tracker.sv
// corner_tracker: per-frame extreme-point finder over a raster-ordered binary mask, with a pixel-count
// pass threshold and a dropout hold. Define CORNER_SMOOTH_EN to average corners across consecutive passes.
module corner_tracker #(
   parameter int FRAME_W   = 800,
   parameter int FRAME_H   = 600,
   parameter int COORD_W   = 10,
   parameter int CNT_W     = 8,
   parameter int MIN_PIX   = 255,
   parameter int MISS_HOLD = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   input  logic                 i_data,
   input  logic                 i_sof,
   output logic                 o_valid,
   output logic                 o_success,
   output logic                 o_held,
   output logic [2*COORD_W-1:0] o_ul_addr,
   output logic [2*COORD_W-1:0] o_ur_addr,
   output logic [2*COORD_W-1:0] o_dl_addr,
   output logic [2*COORD_W-1:0] o_dr_addr
);

   localparam int AW     = 2 * COORD_W;
   localparam int MISS_W = (MISS_HOLD < 1) ? 1 : $clog2(MISS_HOLD + 1);

   localparam logic [COORD_W-1:0] C_ZERO   = {COORD_W{1'b0}};
   localparam logic [COORD_W-1:0] C_ONE    = {{(COORD_W-1){1'b0}}, 1'b1};
   localparam logic [COORD_W-1:0] C_MAX    = {COORD_W{1'b1}};
   localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(FRAME_W - 1);
   localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(FRAME_H - 1);

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(MIN_PIX);
   localparam logic [MISS_W-1:0] MISS_ZERO = {MISS_W{1'b0}};
   localparam logic [MISS_W-1:0] MISS_ONE  = {{(MISS_W-1){1'b0}}, 1'b1};
   localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_HOLD);

   localparam logic [AW-1:0] DEF_UL    = {C_ZERO, C_ZERO};
   localparam logic [AW-1:0] DEF_UR    = {C_ZERO, COL_LAST};
   localparam logic [AW-1:0] DEF_DL    = {ROW_LAST, C_ZERO};
   localparam logic [AW-1:0] DEF_DR    = {ROW_LAST, COL_LAST};
   localparam logic [AW-1:0] SEN_TOP   = {C_MAX, C_ZERO};
   localparam logic [AW-1:0] SEN_BOT   = {C_ZERO, C_ZERO};
   localparam logic [AW-1:0] SEN_LEFT  = {C_ZERO, C_MAX};
   localparam logic [AW-1:0] SEN_RIGHT = {C_ZERO, C_ZERO};

`ifdef CORNER_SMOOTH_EN
   function automatic logic [AW-1:0] smooth_addr(input logic [AW-1:0] prev, input logic [AW-1:0] cur);
      logic [COORD_W:0] row_sum;
      logic [COORD_W:0] col_sum;
      row_sum = {1'b0, prev[AW-1:COORD_W]} + {1'b0, cur[AW-1:COORD_W]} + {C_ZERO, 1'b1};
      col_sum = {1'b0, prev[COORD_W-1:0]} + {1'b0, cur[COORD_W-1:0]} + {C_ZERO, 1'b1};
      return {row_sum[COORD_W:1], col_sum[COORD_W:1]};
   endfunction
`endif

   logic [COORD_W-1:0] row_r, col_r;
   logic [AW-1:0]      top_r, bot_r, left_r, right_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [MISS_W-1:0]  miss_r;
   logic               valid_r, success_r, held_r;
   logic [AW-1:0]      ul_r, ur_r, dl_r, dr_r;

   logic [COORD_W-1:0] pos_row_s, pos_col_s, row_next_s, col_next_s;
   logic               first_s, frame_end_s, pass_s;
   logic [AW-1:0]      top_base_s, bot_base_s, left_base_s, right_base_s;
   logic [AW-1:0]      top_next_s, bot_next_s, left_next_s, right_next_s;
   logic [CNT_W-1:0]   cnt_base_s, cnt_next_s;
   logic [MISS_W-1:0]  miss_n_s;
   logic               success_n_s, held_n_s;
   logic [AW-1:0]      ul_n_s, ur_n_s, dl_n_s, dr_n_s;

   // Beat position, raster advance and tracker updates (first beat of a frame compares against sentinels).
   always_comb begin
      pos_row_s = i_sof ? C_ZERO : row_r;
      pos_col_s = i_sof ? C_ZERO : col_r;
      first_s   = (pos_row_s == C_ZERO) && (pos_col_s == C_ZERO);
      frame_end_s = i_valid && (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);

      if (pos_col_s == COL_LAST) begin
         col_next_s = C_ZERO;
         row_next_s = (pos_row_s == ROW_LAST) ? C_ZERO : pos_row_s + C_ONE;
      end else begin
         col_next_s = pos_col_s + C_ONE;
         row_next_s = pos_row_s;
      end

      top_base_s   = first_s ? SEN_TOP   : top_r;
      bot_base_s   = first_s ? SEN_BOT   : bot_r;
      left_base_s  = first_s ? SEN_LEFT  : left_r;
      right_base_s = first_s ? SEN_RIGHT : right_r;
      cnt_base_s   = first_s ? CNT_ZERO  : cnt_r;

      top_next_s   = (i_data && (pos_row_s <  top_base_s[AW-1:COORD_W]))  ? {pos_row_s, pos_col_s} : top_base_s;
      bot_next_s   = (i_data && (pos_row_s >= bot_base_s[AW-1:COORD_W]))  ? {pos_row_s, pos_col_s} : bot_base_s;
      left_next_s  = (i_data && (pos_col_s <= left_base_s[COORD_W-1:0]))  ? {pos_row_s, pos_col_s} : left_base_s;
      right_next_s = (i_data && (pos_col_s >  right_base_s[COORD_W-1:0])) ? {pos_row_s, pos_col_s} : right_base_s;
      cnt_next_s   = (i_data && (cnt_base_s != CNT_MAX)) ? cnt_base_s + CNT_ONE : cnt_base_s;
      pass_s       = (cnt_next_s >= CNT_MIN);
   end

   // End-of-frame decision: pass loads corners, a short miss run holds them, a long one reverts to defaults.
   always_comb begin
      ul_n_s      = ul_r;
      ur_n_s      = ur_r;
      dl_n_s      = dl_r;
      dr_n_s      = dr_r;
      success_n_s = success_r;
      held_n_s    = held_r;
      miss_n_s    = miss_r;
      if (frame_end_s) begin
         if (pass_s) begin
            success_n_s = 1'b1;
            held_n_s    = 1'b0;
            miss_n_s    = MISS_ZERO;
`ifdef CORNER_SMOOTH_EN
            if (success_r) begin
               ul_n_s = smooth_addr(ul_r, top_next_s);
               ur_n_s = smooth_addr(ur_r, right_next_s);
               dl_n_s = smooth_addr(dl_r, left_next_s);
               dr_n_s = smooth_addr(dr_r, bot_next_s);
            end else begin
               ul_n_s = top_next_s;
               ur_n_s = right_next_s;
               dl_n_s = left_next_s;
               dr_n_s = bot_next_s;
            end
`else
            ul_n_s = top_next_s;
            ur_n_s = right_next_s;
            dl_n_s = left_next_s;
            dr_n_s = bot_next_s;
`endif
         end else if (miss_r < MISS_LIM) begin
            success_n_s = 1'b0;
            held_n_s    = 1'b1;
            miss_n_s    = miss_r + MISS_ONE;
         end else begin
            success_n_s = 1'b0;
            held_n_s    = 1'b0;
            miss_n_s    = miss_r;
            ul_n_s      = DEF_UL;
            ur_n_s      = DEF_UR;
            dl_n_s      = DEF_DL;
            dr_n_s      = DEF_DR;
         end
      end else begin
         miss_n_s = miss_r;
      end
   end

   // Raster counters and per-frame trackers advance only on valid beats.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         row_r   <= C_ZERO;
         col_r   <= C_ZERO;
         top_r   <= SEN_TOP;
         bot_r   <= SEN_BOT;
         left_r  <= SEN_LEFT;
         right_r <= SEN_RIGHT;
         cnt_r   <= CNT_ZERO;
      end else if (i_valid) begin
         row_r   <= row_next_s;
         col_r   <= col_next_s;
         top_r   <= top_next_s;
         bot_r   <= bot_next_s;
         left_r  <= left_next_s;
         right_r <= right_next_s;
         cnt_r   <= cnt_next_s;
      end else begin
         row_r   <= row_r;
         col_r   <= col_r;
         top_r   <= top_r;
         bot_r   <= bot_r;
         left_r  <= left_r;
         right_r <= right_r;
         cnt_r   <= cnt_r;
      end
   end

   // Registered corner outputs, status flags and the one-cycle update strobe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_r   <= 1'b0;
         success_r <= 1'b0;
         held_r    <= 1'b0;
         miss_r    <= MISS_ZERO;
         ul_r      <= DEF_UL;
         ur_r      <= DEF_UR;
         dl_r      <= DEF_DL;
         dr_r      <= DEF_DR;
      end else begin
         valid_r   <= frame_end_s;
         success_r <= success_n_s;
         held_r    <= held_n_s;
         miss_r    <= miss_n_s;
         ul_r      <= ul_n_s;
         ur_r      <= ur_n_s;
         dl_r      <= dl_n_s;
         dr_r      <= dr_n_s;
      end
   end

   assign o_valid   = valid_r;
   assign o_success = success_r;
   assign o_held    = held_r;
   assign o_ul_addr = ul_r;
   assign o_ur_addr = ur_r;
   assign o_dl_addr = dl_r;
   assign o_dr_addr = dr_r;

endmodule

// File: tb/tb_corner_tracker.sv
// Scoreboard bench for corner_tracker: a frame-level reference model pushes expected results,
// an independent monitor pops and compares on every o_valid pulse.
module tb_corner_tracker;
   localparam int FW = 16;
   localparam int FH = 8;
   localparam int CW = 4;
   localparam int MINP = 4;
   localparam int MH = 1;
   localparam int CNT_SAT = 15;
`ifdef CORNER_SMOOTH_EN
   localparam bit SMOOTH = 1'b1;
`else
   localparam bit SMOOTH = 1'b0;
`endif

   typedef struct packed {
      logic       success;
      logic       held;
      logic [7:0] ul;
      logic [7:0] ur;
      logic [7:0] dl;
      logic [7:0] dr;
   } exp_t;

   logic clk = 1'b0;
   logic i_rst = 1'b1, i_valid = 1'b0, i_data = 1'b0, i_sof = 1'b0;
   logic o_valid, o_success, o_held;
   logic [7:0] o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr;

   corner_tracker #(.FRAME_W(FW), .FRAME_H(FH), .COORD_W(CW), .CNT_W(4), .MIN_PIX(MINP), .MISS_HOLD(MH)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data), .i_sof(i_sof),
      .o_valid(o_valid), .o_success(o_success), .o_held(o_held),
      .o_ul_addr(o_ul_addr), .o_ur_addr(o_ur_addr), .o_dl_addr(o_dl_addr), .o_dr_addr(o_dr_addr));

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q[$];
   bit   mask [FH][FW];
   int   pos_cnt = 0;

   // reference model state
   logic [7:0] m_ul = 8'h00, m_ur = 8'h0F, m_dl = 8'h70, m_dr = 8'h7F;
   int   m_miss = 0;
   bit   m_succ = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mk(input int r, input int c);
      logic [3:0] rr, cc;
      rr = r[3:0];
      cc = c[3:0];
      return {rr, cc};
   endfunction

   function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
      int r, c;
      r = (int'(a[7:4]) + int'(b[7:4]) + 1) / 2;
      c = (int'(a[3:0]) + int'(b[3:0]) + 1) / 2;
      return mk(r, c);
   endfunction

   // Extreme points from their definitions over the whole mask, then the pass/hold/revert rules.
   task automatic model_frame();
      int pop = 0, tr = -1, tc = 0, br = 0, bc = 0;
      int minc = FW, lr = 0, maxc = -1, rr = 0, sat;
      logic [7:0] t_ul, t_ur, t_dl, t_dr;
      exp_t e;
      for (int r = 0; r < FH; r++)
         for (int c = 0; c < FW; c++)
            if (mask[r][c]) begin
               pop++;
               if (tr < 0) begin tr = r; tc = c; end
               br = r; bc = c;
               if (c < minc) begin minc = c; lr = r; end
               else if (c == minc) lr = r;
               if (c > maxc) begin maxc = c; rr = r; end
            end
      t_ul = mk(tr, tc);
      t_dr = mk(br, bc);
      t_dl = mk(lr, minc);
      t_ur = (maxc <= 0) ? 8'h00 : mk(rr, maxc);
      sat = (pop > CNT_SAT) ? CNT_SAT : pop;
      if (sat >= MINP) begin
         if (SMOOTH && m_succ) begin
            m_ul = avg(m_ul, t_ul); m_ur = avg(m_ur, t_ur);
            m_dl = avg(m_dl, t_dl); m_dr = avg(m_dr, t_dr);
         end else begin
            m_ul = t_ul; m_ur = t_ur; m_dl = t_dl; m_dr = t_dr;
         end
         m_succ = 1'b1; e.held = 1'b0; m_miss = 0;
      end else if (m_miss < MH) begin
         m_succ = 1'b0; e.held = 1'b1; m_miss++;
      end else begin
         m_succ = 1'b0; e.held = 1'b0;
         m_ul = 8'h00; m_ur = 8'h0F; m_dl = 8'h70; m_dr = 8'h7F;
      end
      e.success = m_succ;
      e.ul = m_ul; e.ur = m_ur; e.dl = m_dl; e.dr = m_dr;
      q.push_back(e);
   endtask

   task automatic idle();
      i_valid = 1'b0;
      i_data  = 1'($urandom_range(0, 1));
      i_sof   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      i_sof = 1'b0;
   endtask

   task automatic beat(input bit d, input bit s);
      i_valid = 1'b1; i_data = d; i_sof = s;
      @(posedge clk); #1;
      if (s) pos_cnt = 1;
      else if (pos_cnt == FW * FH) pos_cnt = 1;
      else pos_cnt++;
      i_valid = 1'b0; i_sof = 1'b0; i_data = 1'b0;
   endtask

   task automatic drive_frame(input bit with_sof, input int stall_pct);
      for (int r = 0; r < FH; r++)
         for (int c = 0; c < FW; c++) begin
            while ($urandom_range(0, 99) < stall_pct) idle();
            if (r == FH - 1 && c == FW - 1) model_frame();
            beat(mask[r][c], with_sof && r == 0 && c == 0);
         end
   endtask

   task automatic drive_partial(input int n, input bit sof_first);
      for (int i = 0; i < n; i++) beat(1'($urandom_range(0, 1)), sof_first && i == 0);
   endtask

   task automatic clear_mask();
      for (int r = 0; r < FH; r++)
         for (int c = 0; c < FW; c++) mask[r][c] = 1'b0;
   endtask

   task automatic set_rect(input int r0, input int r1, input int c0, input int c1);
      clear_mask();
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++) mask[r][c] = 1'b1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 i_rst = 1'b0;
      pos_cnt = 0;
      m_ul = 8'h00; m_ur = 8'h0F; m_dl = 8'h70; m_dr = 8'h7F;
      m_miss = 0; m_succ = 1'b0;
      q.delete();
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_success", 32'(o_success), 32'd0);
      check("rst_held", 32'(o_held), 32'd0);
      check("rst_ul", 32'(o_ul_addr), 32'h00);
      check("rst_ur", 32'(o_ur_addr), 32'h0F);
      check("rst_dl", 32'(o_dl_addr), 32'h70);
      check("rst_dr", 32'(o_dr_addr), 32'h7F);
   endtask

   // Monitor: every o_valid pulse must match the oldest pending expectation, FRAME_W*FRAME_H beats after frame start.
   always @(negedge clk) begin
      exp_t e;
      if (!i_rst && o_valid) begin
         if (q.size() == 0) begin
            check("unexpected_o_valid", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("success", 32'(o_success), 32'(e.success));
            check("held", 32'(o_held), 32'(e.held));
            check("ul_addr", 32'(o_ul_addr), 32'(e.ul));
            check("ur_addr", 32'(o_ur_addr), 32'(e.ur));
            check("dl_addr", 32'(o_dl_addr), 32'(e.dl));
            check("dr_addr", 32'(o_dr_addr), 32'(e.dr));
            check("frame_beats", 32'(pos_cnt), 32'(FW * FH));
         end
      end
   end

   initial begin
      clear_mask();
      do_reset();
      check_reset_state();

      set_rect(2, 5, 3, 9);              // square: pass
      drive_frame(1'b1, 0);
      clear_mask();                      // 3 pixels: held
      mask[1][1] = 1'b1; mask[4][7] = 1'b1; mask[6][2] = 1'b1;
      drive_frame(1'b1, 0);
      clear_mask();                      // empty: revert to defaults
      drive_frame(1'b1, 0);
      set_rect(0, FH - 1, 0, FW - 1);    // all ones: counter saturates, still passes
      drive_frame(1'b1, 0);
      set_rect(2, 5, 3, 9);              // stalls must not change the result
      drive_frame(1'b1, 50);

      set_rect(1, 6, 0, 12);             // resync at (3,5) discards the partial frame
      drive_partial(3 * FW + 5, 1'b1);
      drive_frame(1'b1, 20);

      for (int f = 0; f < 10; f++) begin
         int dens = $urandom_range(0, 3);
         clear_mask();
         if (dens == 0) begin
            for (int k = $urandom_range(0, 5); k > 0; k--)
               mask[$urandom_range(0, FH - 1)][$urandom_range(0, FW - 1)] = 1'b1;
         end else begin
            for (int r = 0; r < FH; r++)
               for (int c = 0; c < FW; c++) mask[r][c] = ($urandom_range(0, 99) < dens * 25);
         end
         drive_frame(f[0], 30);
      end

      set_rect(2, 5, 3, 9);
      drive_partial(40, 1'b1);
      do_reset();                        // mid-frame reset
      check_reset_state();
      drive_frame(1'b0, 25);             // next beat is (0,0) without i_sof
      set_rect(5, 6, 8, 12);             // second consecutive pass
      drive_frame(1'b1, 0);

      repeat (4) @(posedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound so a wedged run still reports.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time bound");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end
endmodule
